note_key_scanner: RTL and testbench

- Upstream front end of the single-note player path.
- Samples the raw DE2 push-button note keys and a layer-advance button, then synchronizes and debounces them.
- Tracks the active layer with a three-state cycling FSM.
- Presents a registered one-hot layer code (`state`) and one-hot note code (`note`) that feed the layered note player directly.

---
 rtl/note_key_scanner.sv | 174 +++++++++++++++++
 tb/tb_note_key_scanner.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/note_key_scanner.sv
// note_key_scanner
// Front end of the single-note player path. The raw DE2 note keys and the
// layer-advance button are synchronized and debounced. A three-state FSM
// tracks the active layer. The block presents a registered one-hot layer code
// and a one-hot note code to the layered note player.
//
// Build option: define NOTE_KEY_DEBOUNCE_EN to include the counting
// debouncers. When the macro is not defined, each debounced level is the
// synchronizer output, and the latency drops to 3 edges.
//
// Ports:
//   clk          in  1  system clock (50 MHz)
//   reset_n      in  1  asynchronous active-low reset
//   key_n        in  4  raw note keys, active-low; bit i selects note i
//   layer_btn_n  in  1  raw layer-advance button, active-low
//   state        out 3  one-hot layer: 001 L1, 010 L2, 100 L3
//   note         out 4  one-hot lowest pressed note, 0000 when none
//   key_valid    out 1  high iff note != 0000
//   layer_change out 1  one-cycle pulse coincident with a state update
module note_key_scanner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] key_n,
  input  logic       layer_btn_n,
  output logic [2:0] state,
  output logic [3:0] note,
  output logic       key_valid,
  output logic       layer_change
);

  typedef enum logic [2:0] {
    L1 = 3'b001,
    L2 = 3'b010,
    L3 = 3'b100
  } layer_t;

  // Isolate the lowest set bit; zero input yields zero.
  function automatic logic [3:0] lowest_onehot(input logic [3:0] p);
    return p & (~p + 4'd1);
  endfunction

  logic [4:0] raw_s;
  logic [4:0] sync1_r;
  logic [4:0] sync2_r;
  logic [4:0] deb_s;

  layer_t     layer_r;
  layer_t     layer_next_s;
  logic       layer_prev_r;
  logic       press_s;
  logic [3:0] pressed_s;
  logic       lock_r;
  logic       lock_next_s;
  logic [3:0] note_next_s;
  logic [3:0] note_r;
  logic       key_valid_r;
  logic       layer_change_r;

  // Bit 4 carries the layer button; bits 3:0 carry the note keys.
  assign raw_s = {layer_btn_n, key_n};

  // Two-flop synchronizer. It resets to the released level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_r <= 5'b11111;
      sync2_r <= 5'b11111;
    end else begin
      sync1_r <= raw_s;
      sync2_r <= sync1_r;
    end
  end

`ifdef NOTE_KEY_DEBOUNCE_EN
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  for (genvar i = 0; i < 5; i++) begin : g_deb
    logic             level_r;
    logic [CNT_W-1:0] cnt_r;

    // Accept a new level only after DEBOUNCE_CYCLES consecutive differing
    // samples. Any agreeing sample discards the count.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        level_r <= 1'b1;
        cnt_r   <= CNT_ZERO;
      end else if (sync2_r[i] == level_r) begin
        cnt_r   <= CNT_ZERO;
      end else if (cnt_r == CNT_MAX) begin
        level_r <= sync2_r[i];
        cnt_r   <= CNT_ZERO;
      end else begin
        cnt_r   <= cnt_r + CNT_ONE;
      end
    end

    assign deb_s[i] = level_r;
  end
`else
  assign deb_s = sync2_r;

  // The debounce parameters have no effect in this build. They are still
  // referenced, so out-of-range settings remain visible at elaboration.
  if ((DEBOUNCE_CYCLES < 1) || (CNT_W < 1)) begin : g_param_unused
  end
`endif

  // A press edge on the layer button is a debounced 1->0 transition.
  assign press_s   = layer_prev_r & ~deb_s[4];
  assign pressed_s = ~deb_s[3:0];

  // Layer FSM next state: advance once per press edge.
  always_comb begin
    layer_next_s = layer_r;
    if (press_s) begin
      case (layer_r)
        L1:      layer_next_s = L2;
        L2:      layer_next_s = L3;
        L3:      layer_next_s = L1;
        default: layer_next_s = L1;
      endcase
    end else begin
      layer_next_s = layer_r;
    end
  end

  // Lockout and note encoding. Keys held across a layer change stay muted
  // until every key has been released.
  always_comb begin
    lock_next_s = lock_r;
    note_next_s = 4'b0000;
    if (press_s) begin
      lock_next_s = 1'b1;
    end else if (pressed_s == 4'b0000) begin
      lock_next_s = 1'b0;
    end else begin
      lock_next_s = lock_r;
    end
    if (press_s || lock_r) begin
      note_next_s = 4'b0000;
    end else begin
      note_next_s = lowest_onehot(pressed_s);
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      layer_r        <= L1;
      layer_prev_r   <= 1'b1;
      lock_r         <= 1'b0;
      note_r         <= 4'b0000;
      key_valid_r    <= 1'b0;
      layer_change_r <= 1'b0;
    end else begin
      layer_r        <= layer_next_s;
      layer_prev_r   <= deb_s[4];
      lock_r         <= lock_next_s;
      note_r         <= note_next_s;
      key_valid_r    <= (note_next_s != 4'b0000);
      layer_change_r <= press_s;
    end
  end

  assign state        = layer_r;
  assign note         = note_r;
  assign key_valid    = key_valid_r;
  assign layer_change = layer_change_r;

endmodule

// File: tb/tb_note_key_scanner.sv
// Directed testbench for note_key_scanner with DEBOUNCE_CYCLES = 4. The
// expected latency follows the NOTE_KEY_DEBOUNCE_EN build option.
module tb_note_key_scanner;

  localparam int DEB = 4;
`ifdef NOTE_KEY_DEBOUNCE_EN
  localparam int LAT = DEB + 3;
`else
  localparam int LAT = 3;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] key_n;
  logic       layer_btn_n;
  logic [2:0] state;
  logic [3:0] note;
  logic       key_valid;
  logic       layer_change;

  int passed = 0;
  int total  = 0;
  logic [2:0] cur_state;

  typedef struct packed {
    logic [3:0] key_n;
    logic [3:0] note;
    logic       valid;
  } vec_t;

  vec_t vec [10];

  note_key_scanner #(.DEBOUNCE_CYCLES(DEB), .CNT_W(4)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .key_n(key_n),
    .layer_btn_n(layer_btn_n),
    .state(state),
    .note(note),
    .key_valid(key_valid),
    .layer_change(layer_change)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else passed++;
  endtask

  // Advance n rising edges, then sample 1 ns after the last edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] next_layer(input logic [2:0] s);
    case (s)
      3'b001:  return 3'b010;
      3'b010:  return 3'b100;
      default: return 3'b001;
    endcase
  endfunction

  task automatic layer_press(input int hold);
    int pulses;
    logic [2:0] exp_s;
    pulses = 0;
    exp_s = next_layer(cur_state);
    layer_btn_n = 1'b0;
    for (int i = 1; i <= hold; i++) begin
      step(1);
      if (layer_change === 1'b1) pulses++;
      if (i == LAT - 1) chk("layer_pre", 32'(state), 32'(cur_state));
      if (i == LAT) begin
        chk("layer_upd", 32'(state), 32'(exp_s));
        chk("layer_pulse", 32'(layer_change), 32'(1'b1));
      end
    end
    layer_btn_n = 1'b1;
    for (int i = 1; i <= LAT + 2; i++) begin
      step(1);
      if (layer_change === 1'b1) pulses++;
    end
    chk("layer_once", 32'(pulses), 32'(1));
    chk("layer_final", 32'(state), 32'(exp_s));
    cur_state = exp_s;
  endtask

  initial begin
    logic [3:0] prev_note;
    logic seen;

    vec[0] = '{4'b1111, 4'b0000, 1'b0};
    vec[1] = '{4'b1101, 4'b0010, 1'b1};
    vec[2] = '{4'b1111, 4'b0000, 1'b0};
    vec[3] = '{4'b0110, 4'b0001, 1'b1};
    vec[4] = '{4'b0111, 4'b1000, 1'b1};
    vec[5] = '{4'b1011, 4'b0100, 1'b1};
    vec[6] = '{4'b0000, 4'b0001, 1'b1};
    vec[7] = '{4'b1000, 4'b0001, 1'b1};
    vec[8] = '{4'b0111, 4'b1000, 1'b1};
    vec[9] = '{4'b1111, 4'b0000, 1'b0};

    // Reset state
    reset_n = 1'b0;
    key_n = 4'b1111;
    layer_btn_n = 1'b1;
    cur_state = 3'b001;
    step(3);
    chk("rst_state", 32'(state), 32'(3'b001));
    chk("rst_note", 32'(note), 32'(4'b0000));
    chk("rst_valid", 32'(key_valid), 32'(1'b0));
    chk("rst_lchg", 32'(layer_change), 32'(1'b0));
    reset_n = 1'b1;
    step(2);

    // Table-driven note encoding with exact latency
    prev_note = 4'b0000;
    for (int i = 0; i < 10; i++) begin
      key_n = vec[i].key_n;
      step(LAT - 1);
      chk("tbl_hold", 32'(note), 32'(prev_note));
      step(1);
      chk("tbl_note", 32'(note), 32'(vec[i].note));
      chk("tbl_valid", 32'(key_valid), 32'(vec[i].valid));
      chk("tbl_state", 32'(state), 32'(3'b001));
      prev_note = vec[i].note;
    end

    // Bounce: low 3, high 1, low 3, then released
    seen = 1'b0;
    key_n = 4'b1110;
    for (int i = 0; i < 3; i++) begin step(1); if (note !== 4'b0000) seen = 1'b1; end
    key_n = 4'b1111;
    step(1); if (note !== 4'b0000) seen = 1'b1;
    key_n = 4'b1110;
    for (int i = 0; i < 3; i++) begin step(1); if (note !== 4'b0000) seen = 1'b1; end
    key_n = 4'b1111;
    for (int i = 0; i < LAT + 2; i++) begin step(1); if (note !== 4'b0000) seen = 1'b1; end
`ifdef NOTE_KEY_DEBOUNCE_EN
    chk("bounce_reject", 32'(seen), 32'(1'b0));
`else
    chk("bounce_passthru", 32'(seen), 32'(1'b1));
`endif
    key_n = 4'b1110;
    step(LAT - 1);
    chk("hold_pre", 32'(note), 32'(4'b0000));
    step(1);
    chk("hold_note", 32'(note), 32'(4'b0001));
    key_n = 4'b1111;
    step(LAT);
    chk("hold_rel", 32'(note), 32'(4'b0000));

    // Layer cycle: four presses, then one long hold
    for (int i = 0; i < 4; i++) layer_press(LAT + 2);
    chk("cycle_end", 32'(state), 32'(3'b010));
    layer_press(100);
    chk("long_hold", 32'(state), 32'(3'b100));

    // Lockout: key 2 held across a layer change
    key_n = 4'b1011;
    step(LAT);
    chk("lk_note", 32'(note), 32'(4'b0100));
    layer_press(LAT + 2);
    chk("lk_muted", 32'(note), 32'(4'b0000));
    step(20);
    chk("lk_still", 32'(note), 32'(4'b0000));
    chk("lk_valid", 32'(key_valid), 32'(1'b0));
    key_n = 4'b1111;
    step(LAT + 1);
    key_n = 4'b1011;
    step(LAT);
    chk("lk_repress", 32'(note), 32'(4'b0100));
    chk("lk_repress_v", 32'(key_valid), 32'(1'b1));
    key_n = 4'b1111;
    step(LAT + 1);

    // Simultaneous key press and layer press
    key_n = 4'b1110;
    layer_btn_n = 1'b0;
    step(LAT - 1);
    chk("sim_pre", 32'(state), 32'(cur_state));
    step(1);
    cur_state = next_layer(cur_state);
    chk("sim_state", 32'(state), 32'(cur_state));
    chk("sim_pulse", 32'(layer_change), 32'(1'b1));
    chk("sim_note", 32'(note), 32'(4'b0000));
    layer_btn_n = 1'b1;
    step(LAT + 2);
    chk("sim_locked", 32'(note), 32'(4'b0000));
    key_n = 4'b1111;
    step(LAT + 1);
    key_n = 4'b1110;
    step(LAT);
    chk("sim_repress", 32'(note), 32'(4'b0001));

    // Reset mid-run with a key held
    chk("mid_state_pre", 32'(state), 32'(3'b010));
    reset_n = 1'b0;
    #2;
    chk("mid_state", 32'(state), 32'(3'b001));
    chk("mid_note", 32'(note), 32'(4'b0000));
    chk("mid_valid", 32'(key_valid), 32'(1'b0));
    chk("mid_lchg", 32'(layer_change), 32'(1'b0));
    step(2);
    reset_n = 1'b1;
    step(LAT - 1);
    chk("post_pre", 32'(note), 32'(4'b0000));
    step(1);
    chk("post_note", 32'(note), 32'(4'b0001));
    chk("post_valid", 32'(key_valid), 32'(1'b1));
    chk("post_state", 32'(state), 32'(3'b001));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
